// File: rtl/systolic_ctrl_if.sv
// Bus bundle between systolic_ctrl, the host C streams, the operand memory and the MAC array.
// The controller takes the master side; the surrounding logic takes the slave side.
interface systolic_ctrl_if #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
);
    localparam int IW = $clog2(DIM);

    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         cin_valid;
    logic                         cin_ready;
    logic [DIM-1:0][BITS_C-1:0]   cin_row;
    logic                         mem_rd_en;
    logic [IW-1:0]                mem_addr;
    logic [DIM-1:0][BITS_AB-1:0]  mem_a;
    logic [DIM-1:0][BITS_AB-1:0]  mem_b;
    logic                         arr_en;
    logic                         arr_wren;
    logic [IW-1:0]                arr_crow;
    logic [DIM-1:0][BITS_AB-1:0]  arr_a;
    logic [DIM-1:0][BITS_AB-1:0]  arr_b;
    logic [DIM-1:0][BITS_C-1:0]   arr_cin;
    logic [DIM-1:0][BITS_C-1:0]   arr_cout;
    logic                         cout_valid;
    logic                         cout_ready;
    logic [DIM-1:0][BITS_C-1:0]   cout_row;
    logic [IW-1:0]                cout_idx;

    modport master (
        input  start, cin_valid, cin_row, mem_a, mem_b, arr_cout, cout_ready,
        output busy, done, cin_ready, mem_rd_en, mem_addr, arr_en, arr_wren,
               arr_crow, arr_a, arr_b, arr_cin, cout_valid, cout_row, cout_idx
    );

    modport slave (
        output start, cin_valid, cin_row, mem_a, mem_b, arr_cout, cout_ready,
        input  busy, done, cin_ready, mem_rd_en, mem_addr, arr_en, arr_wren,
               arr_crow, arr_a, arr_b, arr_cin, cout_valid, cout_row, cout_idx
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for a DIM x DIM signed MAC systolic array: C preload, skewed operand feed, result drain.
//   state     | meaning
//   IDLE      | waiting for start
//   LOAD_C    | accepting C preload rows 0..DIM-1
//   COMPUTE   | reading operands, feeding skewed edges, t = 0..3*DIM-2
//   DRAIN     | presenting result rows 0..DIM-1
module systolic_ctrl #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    systolic_ctrl_if.master bus
);
    localparam int IW = $clog2(DIM);
    localparam int TW = $clog2(3 * DIM - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(3 * DIM - 2);
    localparam logic [TW-1:0] T_RDEND  = TW'(DIM);
    localparam logic [IW-1:0] ROW_LAST = IW'(DIM - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD_C  = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] row_q, row_d;
    logic [TW-1:0] t_q, t_d;
    logic          done_q, done_d;
    logic          rd_vld_q;
    logic          rd_now;

    logic [DIM-1:0][BITS_AB-1:0] feed_a, feed_b;
    logic [DIM-1:0][BITS_AB-1:0] skew_a, skew_b;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        t_d     = t_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // the IDLE cycle that shows done still refuses a new start
                if (bus.start && !done_q) begin
                    state_d = S_LOAD_C;
                    row_d   = '0;
                end
            end
            S_LOAD_C: begin
                if (bus.cin_valid) begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_COMPUTE;
                        row_d   = '0;
                        t_d     = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (t_q == T_LAST) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus.cout_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_now = (state_q == S_COMPUTE) && (t_q < T_RDEND);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            t_q      <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            t_q      <= t_d;
            done_q   <= done_d;
            rd_vld_q <= rd_now;
        end
    end

    // memory data is trusted only in the cycle after a read strobe
    assign feed_a = rd_vld_q ? bus.mem_a : '0;
    assign feed_b = rd_vld_q ? bus.mem_b : '0;

    assign skew_a[0] = feed_a[0];
    assign skew_b[0] = feed_b[0];

    for (genvar r = 1; r < DIM; r++) begin : g_skew
        logic [r-1:0][BITS_AB-1:0] a_q;
        logic [r-1:0][BITS_AB-1:0] b_q;

        always_ff @(posedge clk) begin
            if (!rst_n || state_q != S_COMPUTE) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                for (int j = r - 1; j > 0; j--) begin
                    a_q[j] <= a_q[j-1];
                    b_q[j] <= b_q[j-1];
                end
                a_q[0] <= feed_a[r];
                b_q[0] <= feed_b[r];
            end
        end

        assign skew_a[r] = a_q[r-1];
        assign skew_b[r] = b_q[r-1];
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.cin_ready  = (state_q == S_LOAD_C);
    assign bus.arr_wren   = (state_q == S_LOAD_C) && bus.cin_valid;
    assign bus.arr_cin    = (state_q == S_LOAD_C) ? bus.cin_row : '0;
    assign bus.arr_crow   = (state_q == S_LOAD_C || state_q == S_DRAIN) ? row_q : '0;
    assign bus.mem_rd_en  = rd_now;
    assign bus.mem_addr   = rd_now ? t_q[IW-1:0] : '0;
    assign bus.arr_en     = (state_q == S_COMPUTE) && (t_q != '0);
    assign bus.arr_a      = (state_q == S_COMPUTE) ? skew_a : '0;
    assign bus.arr_b      = (state_q == S_COMPUTE) ? skew_b : '0;
    assign bus.cout_valid = (state_q == S_DRAIN);
    assign bus.cout_row   = (state_q == S_DRAIN) ? bus.arr_cout : '0;
    assign bus.cout_idx   = (state_q == S_DRAIN) ? row_q : '0;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl at DIM=4 with a behavioural operand memory and output-stationary MAC array,
// results compared against C = Cin + A x B computed directly.
module tb_systolic_ctrl;
    localparam int BA    = 8;
    localparam int BC    = 16;
    localparam int DIM   = 4;
    localparam int TLAST = 3 * DIM - 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) bus ();

    systolic_ctrl #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int jobs_completed = 0;

    logic signed [BA-1:0] ma    [DIM][DIM];   // A[i][k]
    logic signed [BA-1:0] mb    [DIM][DIM];   // B[k][j]
    logic signed [BC-1:0] mc    [DIM][DIM];   // Cin
    logic signed [BC-1:0] ref_c [DIM][DIM];
    logic signed [BC-1:0] got_c [DIM][DIM];

    // operand memory: one-cycle read latency, junk on cycles without a read
    always @(posedge clk) begin
        for (int r = 0; r < DIM; r++) begin
            bus.mem_a[r] <= bus.mem_rd_en ? ma[r][bus.mem_addr] : BA'($urandom);
            bus.mem_b[r] <= bus.mem_rd_en ? mb[bus.mem_addr][r] : BA'($urandom);
        end
    end

    // MAC array: operand pipeline shifts every cycle, accumulation only while enabled
    logic signed [BC-1:0] acc [DIM][DIM];
    logic signed [BA-1:0] pa  [DIM][DIM];
    logic signed [BA-1:0] pb  [DIM][DIM];
    logic signed [BA-1:0] ain, bin;
    always @(posedge clk) begin
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (j == 0) ain = bus.arr_a[i]; else ain = pa[i][j-1];
                if (i == 0) bin = bus.arr_b[j]; else bin = pb[i-1][j];
                pa[i][j] <= ain;
                pb[i][j] <= bin;
                if (bus.arr_en) acc[i][j] <= acc[i][j] + ain * bin;
                if (bus.arr_wren && int'(bus.arr_crow) == i) acc[i][j] <= bus.arr_cin[j];
            end
        end
    end
    for (genvar j = 0; j < DIM; j++) begin : g_cout
        assign bus.arr_cout[j] = acc[bus.arr_crow][j];
    end

    always @(negedge clk) if (bus.done === 1'b1) done_seen++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " busy"},       bus.busy, 0);
        chk({tag, " done"},       bus.done, 0);
        chk({tag, " cin_ready"},  bus.cin_ready, 0);
        chk({tag, " mem_rd_en"},  bus.mem_rd_en, 0);
        chk({tag, " mem_addr"},   bus.mem_addr, 0);
        chk({tag, " arr_en"},     bus.arr_en, 0);
        chk({tag, " arr_wren"},   bus.arr_wren, 0);
        chk({tag, " arr_crow"},   bus.arr_crow, 0);
        chk({tag, " arr_a"},      bus.arr_a, 0);
        chk({tag, " arr_b"},      bus.arr_b, 0);
        chk({tag, " arr_cin"},    bus.arr_cin, 0);
        chk({tag, " cout_valid"}, bus.cout_valid, 0);
        chk({tag, " cout_row"},   bus.cout_row, 0);
        chk({tag, " cout_idx"},   bus.cout_idx, 0);
    endtask

    function automatic void compute_ref();
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                int s;
                s = int'(mc[i][j]);
                for (int k = 0; k < DIM; k++) s += int'(ma[i][k]) * int'(mb[k][j]);
                ref_c[i][j] = BC'(s);
                got_c[i][j] = '0;
            end
        end
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = BA'($urandom);
                mb[i][j] = BA'($urandom);
                mc[i][j] = BC'($urandom);
            end
        end
    endtask

    // cin_mode: 0 always valid, 1 alternate cycles, 2 random
    // cout_mode: 0 always ready, 1 stall row 2 for three cycles, 2 random
    task automatic run_job(input int cin_mode, input int cout_mode, input bit spam, input int abort_t);
        int  phase, cin_idx, t, drow, en_cnt, stall, idle_left;
        bit  alt, v;
        int  addr_seq[$];
        logic [DIM-1:0][BC-1:0] exp_row;
        compute_ref();
        phase = 0; cin_idx = 0; t = 0; drow = 0; en_cnt = 0; stall = 0; idle_left = 3; alt = 1'b0;
        for (int cyc = 0; cyc < 400 && phase != 9; cyc++) begin
            @(posedge clk); #1;
            bus.start      = 1'b0;
            bus.cin_valid  = 1'b0;
            bus.cout_ready = 1'b0;
            bus.cin_row    = {$urandom, $urandom};
            case (phase)
                0: bus.start = 1'b1;
                1: begin
                    alt = ~alt;
                    if (cin_mode == 0) v = 1'b1;
                    else if (cin_mode == 1) v = alt;
                    else v = 1'($urandom_range(0, 1));
                    bus.cin_valid = v;
                    if (v) for (int j = 0; j < DIM; j++) bus.cin_row[j] = mc[cin_idx][j];
                    bus.start = spam;
                end
                2: begin
                    bus.cin_valid = 1'($urandom_range(0, 1));
                    if (t == abort_t) rst_n = 1'b0;
                end
                3: begin
                    if (cout_mode == 0) bus.cout_ready = 1'b1;
                    else if (cout_mode == 1) begin
                        if (drow == 2 && stall < 3) stall++;
                        else bus.cout_ready = 1'b1;
                    end else bus.cout_ready = 1'($urandom_range(0, 1));
                    bus.start = spam;
                end
                4: bus.start = spam;
                5: rst_n = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            case (phase)
                0: begin
                    chk("idle busy", bus.busy, 0);
                    phase = 1;
                end
                1: begin
                    chk("load cin_ready", bus.cin_ready, 1);
                    chk("load busy", bus.busy, 1);
                    chk("load arr_en", bus.arr_en, 0);
                    chk("load arr_wren", bus.arr_wren, bus.cin_valid);
                    if (bus.cin_valid) begin
                        for (int j = 0; j < DIM; j++) exp_row[j] = mc[cin_idx][j];
                        chk("load arr_crow", bus.arr_crow, cin_idx);
                        chk("load arr_cin", bus.arr_cin, exp_row);
                        cin_idx++;
                        if (cin_idx == DIM) begin phase = 2; t = 0; end
                    end
                end
                2: begin
                    chk("comp cin_ready", bus.cin_ready, 0);
                    chk("comp arr_wren", bus.arr_wren, 0);
                    chk("comp cout_valid", bus.cout_valid, 0);
                    chk("comp arr_en", bus.arr_en, (t >= 1) ? 1 : 0);
                    chk("comp mem_rd_en", bus.mem_rd_en, (t < DIM) ? 1 : 0);
                    chk("comp mem_addr", bus.mem_addr, (t < DIM) ? t : 0);
                    for (int r = 0; r < DIM; r++) begin
                        int k;
                        k = t - 1 - r;
                        chk("skew arr_a", bus.arr_a[r], (k >= 0 && k < DIM) ? $unsigned(ma[r][k]) : 0);
                        chk("skew arr_b", bus.arr_b[r], (k >= 0 && k < DIM) ? $unsigned(mb[k][r]) : 0);
                    end
                    if (bus.arr_en) en_cnt++;
                    if (bus.mem_rd_en) addr_seq.push_back(int'(bus.mem_addr));
                    if (t == abort_t) phase = 5;
                    else if (t == TLAST) begin phase = 3; drow = 0; end
                    else t++;
                end
                3: begin
                    chk("drain cout_valid", bus.cout_valid, 1);
                    chk("drain cout_idx", bus.cout_idx, drow);
                    chk("drain arr_crow", bus.arr_crow, drow);
                    chk("drain arr_en", bus.arr_en, 0);
                    chk("drain done", bus.done, 0);
                    for (int j = 0; j < DIM; j++)
                        chk("drain cout_row", bus.cout_row[j], $unsigned(ref_c[drow][j]));
                    if (bus.cout_ready) begin
                        for (int j = 0; j < DIM; j++) got_c[drow][j] = bus.cout_row[j];
                        drow++;
                        if (drow == DIM) phase = 4;
                    end
                end
                4: begin
                    chk("end done", bus.done, 1);
                    chk("end busy", bus.busy, 0);
                    chk("end cout_valid", bus.cout_valid, 0);
                    phase = 6;
                end
                6: begin
                    chk("after done pulse", bus.done, 0);
                    chk("after done busy", bus.busy, 0);
                    phase = 9;
                end
                5: begin
                    check_all_zero("abort");
                    phase = 7;
                end
                7: begin
                    chk("abort no done", bus.done, 0);
                    chk("abort idle busy", bus.busy, 0);
                    idle_left--;
                    if (idle_left == 0) phase = 9;
                end
                default: ;
            endcase
        end
        chk("job reached end", phase, 9);
        if (abort_t < 0) begin
            jobs_completed++;
            chk("arr_en cycles", en_cnt, TLAST);
            chk("mem_addr count", addr_seq.size(), DIM);
            for (int k = 0; k < addr_seq.size() && k < DIM; k++) chk("mem_addr seq", addr_seq[k], k);
        end
    endtask

    typedef struct {
        int a;
        int b;
        int cin;
        int exp;
    } uvec_t;

    initial begin
        uvec_t tbl[5];
        tbl = '{'{2, -3, 100, 76}, '{0, 5, 7, 7}, '{-128, -128, 0, 0},
                '{127, -128, 0, 512}, '{1, 1, -1, 3}};

        bus.start = 1'b0; bus.cin_valid = 1'b0; bus.cin_row = '0; bus.cout_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // identity A, B[i][j] = 4i+j, Cin = 0
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = (i == j) ? 8'sd1 : 8'sd0;
                mb[i][j] = BA'(i * DIM + j);
                mc[i][j] = '0;
            end
        run_job(0, 0, 1'b0, -1);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) chk("identity result", $unsigned(got_c[i][j]), i * DIM + j);

        // uniform matrices with hand-computed results, including 16-bit wrap
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    ma[i][j] = BA'(tbl[n].a);
                    mb[i][j] = BA'(tbl[n].b);
                    mc[i][j] = BC'(tbl[n].cin);
                end
            run_job(0, 0, 1'b0, -1);
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    chk("table result", $unsigned(got_c[i][j]), $unsigned(BC'(tbl[n].exp)));
        end

        // skew: only k=0 carries data
        fill_random();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[i][j] = (j == 0) ? BA'(i + 1) : 8'sd0;
                mb[i][j] = (i == 0) ? BA'(j + 1) : 8'sd0;
            end
        run_job(0, 0, 1'b0, -1);

        // cin gaps and a three-cycle stall on row 2
        fill_random();
        run_job(1, 1, 1'b0, -1);

        // reset at t=5, then a fresh job
        fill_random();
        run_job(0, 0, 1'b0, 5);
        fill_random();
        run_job(0, 0, 1'b0, -1);

        // start pulses during LOAD_C, DRAIN and the done cycle
        fill_random();
        run_job(0, 0, 1'b1, -1);

        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_job(2, 2, 1'($urandom_range(0, 1)), -1);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("done pulse count", done_seen, jobs_completed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
